// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle main control FSM for the ARM-subset processor
// Sequences FETCH..writeback and drives Moore control requests for CondLogic and the datapath.
module mc_control_fsm (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic       Undef,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  state_e state_q, state_d;

  logic [3:0] cmd;
  logic [1:0] alu_dec;
  logic [1:0] flag_dec;
  logic       no_write;
  logic       arith;
  logic       known;

  assign cmd = Funct[4:1];

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Funct decode: ALU op, compare-only qualifier and flag-update mask
  always_comb begin
    alu_dec  = 2'b00;
    no_write = 1'b0;
    arith    = 1'b0;
    known    = 1'b1;
    case (cmd)
      4'b0100: begin alu_dec = 2'b00; arith = 1'b1; end
      4'b0010: begin alu_dec = 2'b01; arith = 1'b1; end
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      4'b1010: begin alu_dec = 2'b01; arith = 1'b1; no_write = 1'b1; end
      4'b1011: begin alu_dec = 2'b00; arith = 1'b1; no_write = 1'b1; end
      default: known = 1'b0;
    endcase
    if (no_write)   flag_dec = 2'b11;
    else if (known) flag_dec = {Funct[0], Funct[0] & arith};
    else            flag_dec = 2'b00;
  end

  always_comb begin
    state_d    = S_FETCH;
    PCS        = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    FlagW      = 2'b00;
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    Undef      = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: begin
            state_d = S_FETCH;
            Undef   = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        PCS       = (Rd == 4'd15);
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_dec;
        FlagW      = flag_dec;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        RegW = ~no_write;
        PCS  = (Rd == 4'd15) & ~no_write;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCS       = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset squashes every request in the same cycle, including an aborted write
    if (RESET) begin
      PCS        = 1'b0;
      RegW       = 1'b0;
      MemW       = 1'b0;
      FlagW      = 2'b00;
      IRWrite    = 1'b0;
      NextPC     = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = 2'b00;
      Undef      = 1'b0;
    end
  end

  assign State = RESET ? 4'd0 : state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - table-driven bench for mc_control_fsm
module tb_mc_control_fsm;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS, RegW, MemW, IRWrite, NextPC, AdrSrc, ALUSrcA, Undef;
  logic [1:0] FlagW, ResultSrc, ALUSrcB, ALUControl;
  logic [3:0] State;

  mc_control_fsm dut (
    .CLK(CLK), .RESET(RESET), .Op(Op), .Funct(Funct), .Rd(Rd),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .Undef(Undef), .State(State)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [19:0] exp;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  logic [19:0] act;
  assign act = {State, PCS, RegW, MemW, FlagW, IRWrite, NextPC, AdrSrc,
                ResultSrc, ALUSrcA, ALUSrcB, ALUControl, Undef};

  function automatic logic [19:0] ex(
    input logic [3:0] st, input logic pcs, input logic regw, input logic memw,
    input logic [1:0] fw, input logic irw, input logic npc, input logic adr,
    input logic [1:0] rs, input logic asa, input logic [1:0] asb,
    input logic [1:0] alu, input logic und);
    return {st, pcs, regw, memw, fw, irw, npc, adr, rs, asa, asb, alu, und};
  endfunction

  task automatic add(input logic r, input logic [1:0] o, input logic [5:0] f,
                     input logic [3:0] d, input logic [19:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.rd = d; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Runs one instruction from FETCH back to FETCH and checks cycle count and pulse counts
  task automatic run_instr(input string name, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] d, input int cyc_e, input int irw_e,
                           input int regw_e, input int memw_e, input int pcs_e);
    int cyc, irw, regw, memw, pcs;
    cyc = 0; irw = 0; regw = 0; memw = 0; pcs = 0;
    Op = o; Funct = f; Rd = d;
    do begin
      #1;
      irw  += int'(IRWrite);
      regw += int'(RegW);
      memw += int'(MemW);
      pcs  += int'(PCS);
      @(negedge CLK);
      cyc++;
    end while (State != 4'd0 && cyc < 30);
    check(name, {cyc[7:0], irw[3:0], regw[3:0], memw[3:0], pcs[3:0]},
          {cyc_e[7:0], irw_e[3:0], regw_e[3:0], memw_e[3:0], pcs_e[3:0]});
  endtask

  initial begin
    logic [19:0] fe, de, deu;
    RESET = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
    fe  = ex(0, 0, 0, 0, 0, 1, 1, 0, 2, 1, 2, 0, 0);
    de  = ex(1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 2, 0, 0);
    deu = ex(1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 2, 0, 1);

    for (int i = 0; i < 3; i++) add(1, 2'b01, 6'b011001, 4'd15, 20'd0);
    // ADDS R1
    add(0, 2'b00, 6'b001001, 4'd1, fe);
    add(0, 2'b00, 6'b001001, 4'd1, de);
    add(0, 2'b00, 6'b001001, 4'd1, ex(6, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 2'b00, 6'b001001, 4'd1, ex(8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // LDR PC
    add(0, 2'b01, 6'b011001, 4'd15, fe);
    add(0, 2'b01, 6'b011001, 4'd15, de);
    add(0, 2'b01, 6'b011001, 4'd15, ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(0, 2'b01, 6'b011001, 4'd15, ex(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    add(0, 2'b01, 6'b011001, 4'd15, ex(4, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // STR
    add(0, 2'b01, 6'b011000, 4'd2, fe);
    add(0, 2'b01, 6'b011000, 4'd2, de);
    add(0, 2'b01, 6'b011000, 4'd2, ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(0, 2'b01, 6'b011000, 4'd2, ex(5, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // CMP
    add(0, 2'b00, 6'b010101, 4'd0, fe);
    add(0, 2'b00, 6'b010101, 4'd0, de);
    add(0, 2'b00, 6'b010101, 4'd0, ex(6, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0));
    add(0, 2'b00, 6'b010101, 4'd0, ex(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // SUB immediate to PC, no S
    add(0, 2'b00, 6'b100100, 4'd15, fe);
    add(0, 2'b00, 6'b100100, 4'd15, de);
    add(0, 2'b00, 6'b100100, 4'd15, ex(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    add(0, 2'b00, 6'b100100, 4'd15, ex(8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // ORRS / ANDS / CMN (no S) / EOR-S (unsupported cmd) execute and writeback
    add(0, 2'b00, 6'b011001, 4'd3, fe);
    add(0, 2'b00, 6'b011001, 4'd3, de);
    add(0, 2'b00, 6'b011001, 4'd3, ex(6, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 3, 0));
    add(0, 2'b00, 6'b011001, 4'd3, ex(8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 2'b00, 6'b000001, 4'd4, fe);
    add(0, 2'b00, 6'b000001, 4'd4, de);
    add(0, 2'b00, 6'b000001, 4'd4, ex(6, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 2, 0));
    add(0, 2'b00, 6'b000001, 4'd4, ex(8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 2'b00, 6'b010110, 4'd15, fe);
    add(0, 2'b00, 6'b010110, 4'd15, de);
    add(0, 2'b00, 6'b010110, 4'd15, ex(6, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 2'b00, 6'b010110, 4'd15, ex(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 2'b00, 6'b000011, 4'd5, fe);
    add(0, 2'b00, 6'b000011, 4'd5, de);
    add(0, 2'b00, 6'b000011, 4'd5, ex(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 2'b00, 6'b000011, 4'd5, ex(8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // B
    add(0, 2'b10, 6'b000000, 4'd0, fe);
    add(0, 2'b10, 6'b000000, 4'd0, de);
    add(0, 2'b10, 6'b000000, 4'd0, ex(9, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0));
    // Undefined op
    add(0, 2'b11, 6'b000000, 4'd0, fe);
    add(0, 2'b11, 6'b000000, 4'd0, deu);
    // STR aborted by reset in the MemW cycle
    add(0, 2'b01, 6'b011000, 4'd2, fe);
    add(0, 2'b01, 6'b011000, 4'd2, de);
    add(0, 2'b01, 6'b011000, 4'd2, ex(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(1, 2'b01, 6'b011000, 4'd2, 20'd0);
    add(0, 2'b01, 6'b011000, 4'd2, fe);

    foreach (vq[i]) begin
      @(negedge CLK);
      RESET = vq[i].rst; Op = vq[i].op; Funct = vq[i].funct; Rd = vq[i].rd;
      #1;
      check($sformatf("vec%0d", i), {12'd0, act}, {12'd0, vq[i].exp});
    end

    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    run_instr("cpi_add",  2'b00, 6'b001000, 4'd2,  4, 1, 1, 0, 0);
    run_instr("cpi_ldr",  2'b01, 6'b011001, 4'd4,  5, 1, 1, 0, 0);
    run_instr("cpi_str",  2'b01, 6'b011000, 4'd4,  4, 1, 0, 1, 0);
    run_instr("cpi_b",    2'b10, 6'b000000, 4'd0,  3, 1, 0, 0, 1);
    run_instr("cpi_und",  2'b11, 6'b000000, 4'd0,  2, 1, 0, 0, 0);
    run_instr("cpi_cmp",  2'b00, 6'b010101, 4'd15, 4, 1, 0, 0, 0);
    run_instr("cpi_ldpc", 2'b01, 6'b011001, 4'd15, 5, 1, 1, 0, 1);

    // ADD to PC aborted by reset in ALUWB: no RegW/PCS, FETCH follows
    Op = 2'b00; Funct = 6'b001000; Rd = 4'd15;
    @(negedge CLK); @(negedge CLK); @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("abort_aluwb", {29'd0, RegW, PCS, 1'b0} | {28'd0, State}, 32'd0);
    @(negedge CLK); RESET = 1'b0;
    #1;
    check("after_abort", {27'd0, State, IRWrite}, {27'd0, 4'd0, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
